// File: rtl/uart_aux_bridge_pkg.sv
// Shared constants and state encoding for the console-to-aux-RAM bridge.
// Byte codes follow the ASCII console protocol: 'R', 'W', 'K', '?'.
package uart_aux_bridge_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_ACCESS  = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    function automatic logic is_command(input logic [7:0] b);
        return (b == CMD_READ) || (b == CMD_WRITE);
    endfunction

endpackage

// File: rtl/uart_aux_bridge_timer.sv
// Saturating inter-byte idle counter. expired is high in the cycle whose
// clock edge would bring the count up to TIMEOUT_CYCLES.
module uart_aux_bridge_timer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg >= LAST);

endmodule

// File: rtl/uart_aux_bridge.sv
// Console command bridge onto the shared aux RAM; the CPU port always has
// priority and the bridge simply retries its access until the bus is free.
module uart_aux_bridge
    import uart_aux_bridge_pkg::*;
#(
    parameter int AUX_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_tdata,
    input  logic                      rx_tvalid,
    output logic                      rx_tready,
    output logic [7:0]                tx_tdata,
    output logic                      tx_tvalid,
    input  logic                      tx_tready,
    input  logic [AUX_ADDR_WIDTH-1:0] cpu_adr_i,
    input  logic [7:0]                cpu_dat_i,
    input  logic                      cpu_we_i,
    input  logic                      cpu_re_i,
    output logic [7:0]                cpu_dat_o,
    output logic [AUX_ADDR_WIDTH-1:0] mem_adr_o,
    output logic [7:0]                mem_dat_o,
    output logic                      mem_we_o,
    input  logic [7:0]                mem_dat_i,
    output logic                      busy_o,
    output logic                      timeout_o
);

    state_t                    state_reg;
    logic [7:0]                addr_hi_reg;
    logic [AUX_ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]                data_reg;
    logic                      is_write_reg;
    logic [7:0]                tx_tdata_reg;
    logic                      tx_tvalid_reg;
    logic                      timeout_reg;

    logic cpu_strobe;
    logic rx_fire;
    logic waiting;
    logic expired;
    logic bridge_we;

    assign cpu_strobe = cpu_we_i || cpu_re_i;
    assign waiting    = (state_reg == ST_ADDR_HI) || (state_reg == ST_ADDR_LO) ||
                        (state_reg == ST_DATA);
    assign rx_tready  = waiting || (state_reg == ST_IDLE);
    assign rx_fire    = rx_tvalid && rx_tready;

    // Gating with rst keeps a reset cycle landing in ACCESS from writing.
    assign bridge_we = (state_reg == ST_ACCESS) && is_write_reg && !cpu_strobe && !rst;

    assign mem_adr_o = cpu_strobe ? cpu_adr_i : addr_reg;
    assign mem_dat_o = cpu_strobe ? cpu_dat_i : data_reg;
    assign mem_we_o  = cpu_strobe ? cpu_we_i  : bridge_we;
    assign cpu_dat_o = mem_dat_i;

    assign tx_tdata  = tx_tdata_reg;
    assign tx_tvalid = tx_tvalid_reg;
    assign busy_o    = (state_reg != ST_IDLE);
    assign timeout_o = timeout_reg;

    uart_aux_bridge_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_fire || !waiting),
        .enable  (waiting && !rx_fire),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            addr_hi_reg   <= 8'h00;
            addr_reg      <= '0;
            data_reg      <= 8'h00;
            is_write_reg  <= 1'b0;
            tx_tdata_reg  <= 8'h00;
            tx_tvalid_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (rx_fire) begin
                        if (is_command(rx_tdata)) begin
                            is_write_reg <= (rx_tdata == CMD_WRITE);
                            state_reg    <= ST_ADDR_HI;
                        end else begin
                            tx_tdata_reg  <= RSP_ERR;
                            tx_tvalid_reg <= 1'b1;
                            state_reg     <= ST_RESP;
                        end
                    end
                end
                ST_ADDR_HI: begin
                    if (rx_fire) begin
                        addr_hi_reg <= rx_tdata;
                        state_reg   <= ST_ADDR_LO;
                    end else if (expired) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_ADDR_LO: begin
                    if (rx_fire) begin
                        // Host address bits above the aux width are dropped here.
                        addr_reg  <= AUX_ADDR_WIDTH'({addr_hi_reg, rx_tdata});
                        state_reg <= is_write_reg ? ST_DATA : ST_ACCESS;
                    end else if (expired) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        data_reg  <= rx_tdata;
                        state_reg <= ST_ACCESS;
                    end else if (expired) begin
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!cpu_strobe) begin
                        tx_tdata_reg  <= is_write_reg ? RSP_ACK : mem_dat_i;
                        tx_tvalid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (tx_tready) begin
                        tx_tvalid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_aux_bridge.sv
// Directed bench for uart_aux_bridge with a behavioural async-read aux RAM.
module tb_uart_aux_bridge;

    localparam int AW = 16;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_tdata;
    logic          rx_tvalid;
    logic          rx_tready;
    logic [7:0]    tx_tdata;
    logic          tx_tvalid;
    logic          tx_tready;
    logic [AW-1:0] cpu_adr_i;
    logic [7:0]    cpu_dat_i;
    logic          cpu_we_i;
    logic          cpu_re_i;
    logic [7:0]    cpu_dat_o;
    logic [AW-1:0] mem_adr_o;
    logic [7:0]    mem_dat_o;
    logic          mem_we_o;
    logic [7:0]    mem_dat_i;
    logic          busy_o;
    logic          timeout_o;

    logic [7:0] mem [0:65535];
    int bridge_we_count = 0;
    int to_count = 0;
    int checks = 0;
    int passed = 0;

    uart_aux_bridge #(
        .AUX_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .cpu_adr_i (cpu_adr_i),
        .cpu_dat_i (cpu_dat_i),
        .cpu_we_i  (cpu_we_i),
        .cpu_re_i  (cpu_re_i),
        .cpu_dat_o (cpu_dat_o),
        .mem_adr_o (mem_adr_o),
        .mem_dat_o (mem_dat_o),
        .mem_we_o  (mem_we_o),
        .mem_dat_i (mem_dat_i),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dat_i = mem[mem_adr_o];

    always @(posedge clk) begin
        if (mem_we_o) mem[mem_adr_o] <= mem_dat_o;
        if (mem_we_o && !cpu_we_i) bridge_we_count <= bridge_we_count + 1;
        if (timeout_o) to_count <= to_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        rx_tdata  = b;
        rx_tvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rx_tready) ok = 1'b1;
            step();
        end
        rx_tvalid = 1'b0;
        if (!ok) check("rx_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic get_resp(output logic [7:0] b);
        logic ok;
        ok = 1'b0;
        b = 8'h00;
        tx_tready = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (tx_tvalid) begin
                ok = 1'b1;
                b  = tx_tdata;
            end
            step();
        end
        tx_tready = 1'b0;
        if (!ok) check("tx_wait", {31'd0, ok}, 32'd1);
        $display("resp %02h", b);
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_adr_i = a;
        cpu_dat_i = d;
        cpu_we_i  = 1'b1;
        #1;
        check("cpu_we_mux", {31'd0, mem_we_o}, 32'd1);
        check("cpu_adr_mux", {16'd0, mem_adr_o}, {16'd0, a});
        step();
        cpu_we_i = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        int wc;
        int t0;
        int npulse;
        int pulse_at;

        rst = 1'b1; rx_tdata = 8'h00; rx_tvalid = 1'b0; tx_tready = 1'b0;
        cpu_adr_i = '0; cpu_dat_i = 8'h00; cpu_we_i = 1'b0; cpu_re_i = 1'b0;
        repeat (3) step();
        check("rst_rx_tready", {31'd0, rx_tready}, 32'd1);
        check("rst_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check("rst_tx_tdata", {24'd0, tx_tdata}, 32'h00);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_timeout", {31'd0, timeout_o}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        rst = 1'b0;
        step();

        // write then read back
        wc = bridge_we_count;
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
        check("wr_access_we", {31'd0, mem_we_o}, 32'd1);
        check("wr_access_adr", {16'd0, mem_adr_o}, 32'h1234);
        check("wr_access_dat", {24'd0, mem_dat_o}, 32'hA5);
        check("wr_access_novalid", {31'd0, tx_tvalid}, 32'd0);
        step();
        check("wr_latency_valid", {31'd0, tx_tvalid}, 32'd1);
        get_resp(r);
        check("wr_resp", {24'd0, r}, 32'h4B);
        check("wr_count", bridge_we_count - wc, 32'd1);
        check("wr_mem", {24'd0, mem[16'h1234]}, 32'hA5);
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
        get_resp(r);
        check("rd_resp", {24'd0, r}, 32'hA5);

        // CPU contention across a bridge read
        cpu_write(16'h0010, 8'h3C);
        cpu_write(16'h0077, 8'h99);
        wc = bridge_we_count;
        send_byte(8'h52); send_byte(8'h00);
        cpu_adr_i = 16'h0077;
        cpu_re_i  = 1'b1;
        send_byte(8'h10);
        for (int i = 0; i < 4; i++) begin
            check("cont_adr", {16'd0, mem_adr_o}, 32'h0077);
            check("cont_cpu_dat", {24'd0, cpu_dat_o}, 32'h99);
            check("cont_novalid", {31'd0, tx_tvalid}, 32'd0);
            step();
        end
        cpu_re_i = 1'b0;
        #1;
        check("cont_bridge_adr", {16'd0, mem_adr_o}, 32'h0010);
        check("cont_pending", {31'd0, tx_tvalid}, 32'd0);
        step();
        check("cont_valid", {31'd0, tx_tvalid}, 32'd1);
        check("cont_tdata", {24'd0, tx_tdata}, 32'h3C);
        get_resp(r);
        check("cont_resp", {24'd0, r}, 32'h3C);
        check("cont_no_write", bridge_we_count - wc, 32'd0);

        // unknown opcode then normal read
        cpu_write(16'h0000, 8'h5A);
        send_byte(8'h41);
        get_resp(r);
        check("unk_resp", {24'd0, r}, 32'h3F);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
        get_resp(r);
        check("unk_next_rd", {24'd0, r}, 32'h5A);

        // timeout after a partial write
        wc = bridge_we_count;
        t0 = to_count;
        npulse = 0;
        pulse_at = 0;
        send_byte(8'h57); send_byte(8'h12);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (timeout_o) begin
                npulse++;
                if (pulse_at == 0) pulse_at = k;
            end
        end
        check("to_pulses", npulse, 32'd1);
        check("to_cycle", pulse_at, 32'd8);
        check("to_monitor", to_count - t0, 32'd1);
        check("to_busy", {31'd0, busy_o}, 32'd0);
        check("to_no_resp", {31'd0, tx_tvalid}, 32'd0);
        check("to_no_write", bridge_we_count - wc, 32'd0);

        // a byte arriving on the threshold cycle wins
        t0 = to_count;
        send_byte(8'h57);
        repeat (TO - 1) step();
        send_byte(8'h00); send_byte(8'h30); send_byte(8'h66);
        get_resp(r);
        check("edge_resp", {24'd0, r}, 32'h4B);
        check("edge_no_timeout", to_count - t0, 32'd0);
        check("edge_mem", {24'd0, mem[16'h0030]}, 32'h66);

        // transmit backpressure during a read response
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
        for (int i = 0; i < 10 && !tx_tvalid; i++) step();
        check("bp_valid", {31'd0, tx_tvalid}, 32'd1);
        rx_tdata  = 8'h57;
        rx_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_stable", {23'd0, tx_tvalid, tx_tdata}, 32'h1A5);
            check("bp_rx_tready", {31'd0, rx_tready}, 32'd0);
            step();
        end
        rx_tvalid = 1'b0;
        get_resp(r);
        check("bp_resp", {24'd0, r}, 32'hA5);
        check("bp_rx_ready_after", {31'd0, rx_tready}, 32'd1);

        // reset in the middle of a write command
        cpu_write(16'h0020, 8'h11);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h20);
        check("mid_busy", {31'd0, busy_o}, 32'd1);
        wc = bridge_we_count;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_rx_tready", {31'd0, rx_tready}, 32'd1);
        check("mid_rst_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check("mid_rst_tx_tdata", {24'd0, tx_tdata}, 32'h00);
        check("mid_rst_timeout", {31'd0, timeout_o}, 32'd0);
        check("mid_rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        repeat (3) step();
        check("mid_no_write", bridge_we_count - wc, 32'd0);
        send_byte(8'hEE);
        get_resp(r);
        check("mid_discarded", {24'd0, r}, 32'h3F);
        check("mid_mem", {24'd0, mem[16'h0020]}, 32'h11);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
